// File: rtl/ram_fifo_ctl.sv
// FIFO controller around an external simple-dual-port RAM with one-cycle read latency.
// A two-word output stage (head + skid) hides the RAM latency so push and pop can both run every cycle.
module ram_fifo_ctl #(
    parameter int CAddrLen = 13,
    parameter int CDataLen = 128
) (
    input  logic                AClkH,
    input  logic                AResetH,
    input  logic                AClkHEn,
    input  logic [CDataLen-1:0] AWrData,
    input  logic                AWrValid,
    output logic                AWrReady,
    output logic [CDataLen-1:0] ARdData,
    output logic                ARdValid,
    input  logic                ARdReady,
    output logic [CAddrLen:0]   ALevel,
    output logic [CAddrLen-1:0] ARamAddrWr,
    output logic [CAddrLen-1:0] ARamAddrRd,
    output logic [CDataLen-1:0] ARamMosi,
    output logic                ARamWrEn,
    input  logic [CDataLen-1:0] ARamMiso
);

    localparam logic [CAddrLen:0] Capacity = {1'b1, {CAddrLen{1'b0}}};

    logic [CAddrLen-1:0] wr_ptr;
    logic [CAddrLen-1:0] rd_ptr;
    logic [CAddrLen-1:0] rd_addr_q;
    logic [CAddrLen:0]   level;
    logic [CAddrLen:0]   level_next;
    logic [CAddrLen:0]   unread;
    logic                inflight;
    logic                head_valid;
    logic                skid_valid;
    logic                wr_ready_q;
    logic [CDataLen-1:0] head_data;
    logic [CDataLen-1:0] skid_data;
    logic                push;
    logic                pop;
    logic                issue;
    logic [1:0]          pending;

    // Ready is registered; the reset term only forces it low while reset is asserted.
    assign AWrReady   = wr_ready_q & ~AResetH;
    assign push       = AWrValid & AWrReady & AClkHEn;
    assign pop        = head_valid & ARdReady & AClkHEn;
    assign pending    = {1'b0, head_valid} + {1'b0, skid_valid} + {1'b0, inflight};
    assign issue      = AClkHEn & ~AResetH & (unread != '0) & (pending < (2'd2 + {1'b0, pop}));

    assign ARamWrEn   = push;
    assign ARamAddrWr = wr_ptr;
    assign ARamMosi   = AWrData;
    // Holding the last read address keeps ARamMiso stable across enable stalls.
    assign ARamAddrRd = issue ? rd_ptr : rd_addr_q;

    assign ARdValid   = head_valid;
    assign ARdData    = head_valid ? head_data : '0;
    assign ALevel     = level;

    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
    end

    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_addr_q  <= '0;
            level      <= '0;
            unread     <= '0;
            inflight   <= 1'b0;
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            head_data  <= '0;
            skid_data  <= '0;
            wr_ready_q <= 1'b1;
        end else if (AClkHEn) begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr    <= rd_ptr + 1'b1;
                rd_addr_q <= rd_ptr;
            end
            case ({push, issue})
                2'b10:   unread <= unread + 1'b1;
                2'b01:   unread <= unread - 1'b1;
                default: unread <= unread;
            endcase
            level      <= level_next;
            wr_ready_q <= (level_next < Capacity);
            inflight   <= issue;

            // Returning RAM word lands behind whatever remains in the stage after a pop.
            if (pop) begin
                if (skid_valid) begin
                    head_data  <= skid_data;
                    skid_valid <= inflight;
                    if (inflight) begin
                        skid_data <= ARamMiso;
                    end
                end else begin
                    head_valid <= inflight;
                    head_data  <= inflight ? ARamMiso : '0;
                end
            end else if (inflight) begin
                if (!head_valid) begin
                    head_valid <= 1'b1;
                    head_data  <= ARamMiso;
                end else begin
                    skid_valid <= 1'b1;
                    skid_data  <= ARamMiso;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctl.sv
// Directed bench for ram_fifo_ctl with a behavioural one-cycle-latency RAM and a small capacity.
module tb_ram_fifo_ctl;

    localparam int AW  = 4;
    localparam int DW  = 16;
    localparam int CAP = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW:0]   level;
    logic [AW-1:0] addr_wr;
    logic [AW-1:0] addr_rd;
    logic [DW-1:0] mosi;
    logic          wr_en;
    logic [DW-1:0] miso;
    logic [DW-1:0] mem [CAP];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_fifo_ctl #(.CAddrLen(AW), .CDataLen(DW)) dut (
        .AClkH(clk), .AResetH(rst), .AClkHEn(en),
        .AWrData(wr_data), .AWrValid(wr_valid), .AWrReady(wr_ready),
        .ARdData(rd_data), .ARdValid(rd_valid), .ARdReady(rd_ready),
        .ALevel(level), .ARamAddrWr(addr_wr), .ARamAddrRd(addr_rd),
        .ARamMosi(mosi), .ARamWrEn(wr_en), .ARamMiso(miso)
    );

    always @(posedge clk) begin
        if (wr_en) mem[addr_wr] <= mosi;
        miso <= mem[addr_rd];
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
        step(); step();
        #1;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready_during: got %b want 0", wr_ready); end
        rst = 1'b0;
        #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready_after: got %b want 1", wr_ready); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        checks++; if (addr_rd !== 4'd0) begin errors++; $display("FAIL reset_addr_rd: got %0d want 0", addr_rd); end
    endtask

    task automatic test_first_word();
        wr_data = 16'h00A5; wr_valid = 1'b1; rd_ready = 1'b0;
        #1;
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL first_wr_en: got %b want 1", wr_en); end
        checks++; if (addr_wr !== 4'd0) begin errors++; $display("FAIL first_addr_wr: got %0d want 0", addr_wr); end
        checks++; if (mosi !== 16'h00A5) begin errors++; $display("FAIL first_mosi: got %h want 00a5", mosi); end
        step(); wr_valid = 1'b0; #1;
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL first_level_c1: got %0d want 1", level); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL first_valid_c1: got %b want 0", rd_valid); end
        step(); #1;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL first_valid_c2: got %b want 0", rd_valid); end
        step(); #1;
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL first_valid_c3: got %b want 1", rd_valid); end
        checks++; if (rd_data !== 16'h00A5) begin errors++; $display("FAIL first_data_c3: got %h want 00a5", rd_data); end
        step(); #1;
        checks++; if (rd_data !== 16'h00A5) begin errors++; $display("FAIL first_data_hold: got %h want 00a5", rd_data); end
        rd_ready = 1'b1;
        step(); rd_ready = 1'b0; #1;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL first_level_popped: got %0d want 0", level); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL first_valid_popped: got %b want 0", rd_valid); end
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL first_data_popped: got %h want 0", rd_data); end
    endtask

    task automatic test_stream();
        logic [DW-1:0] push_val;
        logic [DW-1:0] pop_val;
        push_val = 16'h1000;
        pop_val  = 16'h1000;
        for (int i = 0; i < 1000; i++) begin
            wr_data = push_val; wr_valid = 1'b1; rd_ready = 1'b1;
            #1;
            checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL stream_wr_ready i=%0d: got %b want 1", i, wr_ready); end
            if (i >= 3) begin
                checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL stream_valid i=%0d: got %b want 1", i, rd_valid); end
                checks++; if (level !== 5'd3) begin errors++; $display("FAIL stream_level i=%0d: got %0d want 3", i, level); end
            end
            push_val = push_val + 1'b1;
            if (rd_valid === 1'b1) begin
                checks++; if (rd_data !== pop_val) begin errors++; $display("FAIL stream_data i=%0d: got %h want %h", i, rd_data, pop_val); end
                pop_val = pop_val + 1'b1;
            end
            step();
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (rd_valid === 1'b1) begin
                checks++; if (rd_data !== pop_val) begin errors++; $display("FAIL stream_drain_data: got %h want %h", rd_data, pop_val); end
                pop_val = pop_val + 1'b1;
            end
            step();
        end
        rd_ready = 1'b0; #1;
        checks++; if (pop_val !== push_val) begin errors++; $display("FAIL stream_count: popped up to %h want %h", pop_val, push_val); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL stream_level_end: got %0d want 0", level); end
    endtask

    task automatic test_full();
        logic [DW-1:0] exp;
        int cnt;
        rd_ready = 1'b0; wr_valid = 1'b1;
        for (int i = 0; i < CAP; i++) begin
            wr_data = 16'h0200 + 16'(i);
            #1;
            checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL full_fill_ready i=%0d: got %b want 1", i, wr_ready); end
            step();
        end
        wr_data = 16'h0BAD; #1;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", wr_ready); end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_level: got %0d want 16", level); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL full_wr_en: got %b want 0", wr_en); end
        step(); #1;
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_no_overflow: got %0d want 16", level); end
        rd_ready = 1'b1; #1;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_pushpop_ready: got %b want 0", wr_ready); end
        checks++; if (rd_data !== 16'h0200) begin errors++; $display("FAIL full_head: got %h want 0200", rd_data); end
        step(); wr_valid = 1'b0; rd_ready = 1'b0; #1;
        checks++; if (level !== 5'd15) begin errors++; $display("FAIL full_after_pop_level: got %0d want 15", level); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop_ready: got %b want 1", wr_ready); end
        checks++; if (rd_data !== 16'h0201) begin errors++; $display("FAIL full_after_pop_head: got %h want 0201", rd_data); end
        exp = 16'h0201; cnt = 0; rd_ready = 1'b1;
        for (int c = 0; c < 40 && cnt < 15; c++) begin
            #1;
            if (rd_valid === 1'b1) begin
                checks++; if (rd_data !== exp) begin errors++; $display("FAIL full_drain_data: got %h want %h", rd_data, exp); end
                exp = exp + 1'b1; cnt++;
            end
            step();
        end
        rd_ready = 1'b0; #1;
        checks++; if (cnt != 15) begin errors++; $display("FAIL full_drain_count: got %0d want 15", cnt); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL full_drain_level: got %0d want 0", level); end
    endtask

    task automatic test_stall();
        int n;
        int cnt;
        logic [DW-1:0] exp;
        logic prev_en;
        logic [AW:0] prev_lvl;
        rd_ready = 1'b0; n = 0;
        for (int c = 0; c < 60 && n < 3; c++) begin
            en = 1'($urandom_range(0, 1)); wr_data = 16'h0300 + 16'(n); wr_valid = 1'b1;
            #1;
            if (en) n++;
            step();
        end
        wr_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            en = 1'($urandom_range(0, 1));
            #1;
            checks++; if (level !== 5'd3) begin errors++; $display("FAIL stall_level: got %0d want 3", level); end
            if (rd_valid === 1'b1) begin
                checks++; if (rd_data !== 16'h0300) begin errors++; $display("FAIL stall_data_stable: got %h want 0300", rd_data); end
            end
            step();
        end
        en = 1'b1;
        step(); step(); step(); step(); #1;
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", rd_valid); end
        rd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL skid_b2b_valid k=%0d: got %b want 1", k, rd_valid); end
            checks++; if (rd_data !== 16'h0300 + 16'(k)) begin errors++; $display("FAIL skid_b2b_data k=%0d: got %h want %h", k, rd_data, 16'h0300 + 16'(k)); end
            step();
        end
        rd_ready = 1'b0; #1;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL skid_b2b_level: got %0d want 0", level); end
        wr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wr_data = 16'h0310 + 16'(k);
            step();
        end
        wr_valid = 1'b0; rd_ready = 1'b1;
        exp = 16'h0310; cnt = 0; prev_en = 1'b1; prev_lvl = '0;
        for (int c = 0; c < 80 && cnt < 4; c++) begin
            en = 1'($urandom_range(0, 1));
            #1;
            if (!prev_en) begin
                checks++; if (level !== prev_lvl) begin errors++; $display("FAIL stall_en_low_level: got %0d want %0d", level, prev_lvl); end
            end
            if (rd_valid === 1'b1) begin
                checks++; if (rd_data !== exp) begin errors++; $display("FAIL stall_pop_data: got %h want %h", rd_data, exp); end
                if (en) begin exp = exp + 1'b1; cnt++; end
            end
            prev_en = en; prev_lvl = level;
            step();
        end
        en = 1'b1; rd_ready = 1'b0; #1;
        checks++; if (cnt != 4) begin errors++; $display("FAIL stall_pop_count: got %0d want 4", cnt); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL stall_pop_level: got %0d want 0", level); end
    endtask

    task automatic test_reset_mid();
        logic got;
        en = 1'b1; rd_ready = 1'b0; wr_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 16'h0400 + 16'(i);
            step();
        end
        wr_valid = 1'b0; rd_ready = 1'b1; #1;
        checks++; if (level !== 5'd6) begin errors++; $display("FAIL rstmid_level_pre: got %0d want 6", level); end
        step();
        rd_ready = 1'b0; rst = 1'b1; en = 1'b0; #1;
        checks++; if (level !== 5'd5) begin errors++; $display("FAIL rstmid_level_queued: got %0d want 5", level); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_during: got %b want 0", wr_ready); end
        step();
        rst = 1'b0; en = 1'b1; #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", wr_ready); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", rd_valid); end
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL rstmid_data: got %h want 0", rd_data); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL rstmid_level: got %0d want 0", level); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr_en: got %b want 0", wr_en); end
        checks++; if (addr_rd !== 4'd0) begin errors++; $display("FAIL rstmid_addr_rd: got %0d want 0", addr_rd); end
        wr_data = 16'h003C; wr_valid = 1'b1; #1;
        checks++; if (addr_wr !== 4'd0) begin errors++; $display("FAIL rstmid_addr_wr: got %0d want 0", addr_wr); end
        step();
        wr_valid = 1'b0; rd_ready = 1'b1; got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            #1;
            if (rd_valid === 1'b1) begin
                got = 1'b1;
                checks++; if (rd_data !== 16'h003C) begin errors++; $display("FAIL rstmid_first_pop: got %h want 003c", rd_data); end
            end
            step();
        end
        rd_ready = 1'b0; #1;
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL rstmid_timeout: got valid=%b want 1", got); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL rstmid_level_end: got %0d want 0", level); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid_end: got %b want 0", rd_valid); end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_stream();
        test_full();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_fifo_ctl.md
RAM_FIFO_CTL -- requirements
Module: ram_fifo_ctl

Interface
REQ-001 Parameters SHALL be:
- CAddrLen, default 13: RAM address width.
- CDataLen, default 128: data width.
- Capacity = 2**CAddrLen entries.
REQ-002 AClkH  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 AResetH  in  1  reset; synchronous and active-high.
REQ-004 AClkHEn  in  1  clock enable; when low, no state SHALL change and no handshake SHALL complete.
REQ-005 AWrData  in  CDataLen  push data.
REQ-006 AWrValid  in  1  push request.
REQ-007 AWrReady  out  1  push accepted when high; registered, equals (level < capacity).
REQ-008 ARdData  out  CDataLen  head-of-queue data; SHALL be all-zero whenever ARdValid is low.
REQ-009 ARdValid  out  1  head data valid; registered.
REQ-010 ARdReady  in  1  pop request.
REQ-011 ALevel  out  CAddrLen+1  total entries held: RAM unread + in-flight read + output stage.
REQ-012 ARamAddrWr, ARamAddrRd  out  CAddrLen each  write/read addresses to the simple-dual-port RAM.
REQ-013 ARamMosi  out  CDataLen  RAM write data, equals AWrData.
REQ-014 ARamWrEn  out  1  RAM write strobe.
REQ-015 ARamMiso  in  CDataLen  RAM read data, valid one clock after the read address is sampled.

Function
REQ-016 Push SHALL occur when AWrValid & AWrReady & AClkHEn; ARamWrEn SHALL equal that term, and ARamAddrWr SHALL equal the write pointer.
REQ-017 Pop SHALL occur when ARdValid & ARdReady & AClkHEn.
REQ-018 Write and read pointers SHALL be CAddrLen bits and SHALL wrap from 2**CAddrLen-1 to 0.
REQ-019 AWrReady SHALL have no combinational dependency on ARdReady. At full, a simultaneous pop SHALL NOT enable a push in the same cycle.
REQ-020 The output stage SHALL hold up to 2 words: a head register plus a skid register, drained in FIFO order.
REQ-021 A RAM read SHALL be issued in a cycle only when all of the following hold:
- AClkHEn is high.
- The RAM-unread count is > 0.
- (stage occupancy + in-flight − pop) < 2.
REQ-022 Issued reads: ARamAddrRd SHALL equal the read pointer, and the read pointer SHALL increment.
REQ-023 Cycles without an issued read: ARamAddrRd SHALL hold the last issued address, so ARamMiso stays stable across AClkHEn stalls.
REQ-024 An in-flight flag SHALL set on issue. The next enabled edge SHALL load ARamMiso into the head register if the head is empty or being popped, otherwise into the skid register, and SHALL clear the flag.
REQ-025 On a pop with the skid register occupied, the skid word SHALL move to the head on the same edge.
REQ-026 A word pushed at edge k SHALL NOT be read before edge k+1, so read-before-write RAM hazards cannot occur.
REQ-027 First-word latency SHALL be: push in cycle 0, read issued in cycle 1, ARdValid high in cycle 3.
REQ-028 Steady-state throughput SHALL be one push and one pop per enabled cycle.
REQ-029 Simultaneous push and pop SHALL leave ALevel unchanged; push alone SHALL add 1; pop alone SHALL subtract 1.
REQ-030 Level SHALL never exceed 2**CAddrLen and never go below 0; data order SHALL be strictly preserved.

Reset
REQ-031 While AResetH is high at a rising edge, the block SHALL clear pointers, level, in-flight flag and stage occupancy, regardless of AClkHEn.
REQ-032 Outputs during and immediately after reset SHALL be: AWrReady=0 during reset and 1 from the first cycle after; ARdValid=0; ARdData=0; ALevel=0; ARamWrEn=0; ARamAddrRd=0.
REQ-033 Reset mid-operation SHALL discard all stored and in-flight data. RAM contents are not cleared, and RAM data returned after reset SHALL be ignored.

Verification
REQ-034 Push 0xA5 in cycle 0 into an empty FIFO, with ARdReady=0 -> ARdValid=1 and ARdData=0xA5 from cycle 3; ALevel=1 from cycle 1.
REQ-035 Continuous push/pop of an incrementing pattern for 1000 cycles -> one word popped per cycle after fill, in order, with ALevel constant.
REQ-036 Fill to 2**CAddrLen, then assert push+pop together -> AWrReady=0 that cycle; pop accepted; ALevel=capacity−1; AWrReady=1 on the next cycle.
REQ-037 Hold ARdReady=0 with 3 words pushed, and toggle AClkHEn pseudo-randomly during reads -> no data loss or duplication; skid register used; ARdData stable while stalled.
REQ-038 Assert AResetH for 1 cycle with 5 words queued and a read in flight -> all REQ-032 values hold next cycle; a fresh push of 0x3C is the next word popped.
